finv_pipe: RTL and testbench

- Pipelined IEEE-754 single-precision reciprocal unit for the FPU: y = 1/x.
- Accepts one operand per cycle and produces the result a fixed 2 cycles later.
- Also flags results that overflow to infinity from a finite input.
- Internal algorithm is free (table seed + Newton-Raphson, or digit recurrence); only accuracy, special cases and timing are fixed.

---
 rtl/finv_pipe.sv | 181 ++++++++++++++++++
 tb/tb_finv_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/finv_pipe.sv
// finv_pipe: pipelined IEEE-754 binary32 reciprocal, y = 1/x.
//
// One operand per cycle, result two clock edges after the operand is
// sampled. Stage 1 decodes the operand, normalises subnormals with a
// leading-zero count and forms the reciprocal significand by restoring
// division. Stage 2 rounds to nearest-even, resolves underflow/overflow
// and packs the result.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, clears every pipeline register
//   valid_in   x carries a real operand this cycle
//   x          operand {sign, exp[7:0], frac[22:0]}
//   valid_out  y/ovf carry a real result this cycle
//   y          reciprocal, binary32
//   ovf        finite input whose reciprocal rounded to infinity
module finv_pipe #(
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [31:0] x,
   output logic        valid_out,
   output logic [31:0] y,
   output logic        ovf
);

   if (LATENCY != 2) begin : g_latency_check
      $error("finv_pipe: only LATENCY=2 is implemented");
   end

   // Result class carried from stage 1 to stage 2. CLS_ZERO is the all-zero
   // encoding so a cleared stage-1 register packs to y=0, ovf=0.
   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,   // result is +0 (infinite input)
      CLS_FIN  = 2'd1,   // finite input with a nonzero significand
      CLS_INF  = 2'd2,   // result is signed infinity (zero input), ovf=1
      CLS_NAN  = 2'd3    // quiet the input NaN
   } res_cls_t;

   // ---------------------------------------------------------------- stage 1
   logic        sign_in;
   logic [7:0]  exp_in;
   logic [22:0] frac_in;
   logic [4:0]  sh;
   logic [23:0] mant;
   logic        m_one;
   logic [24:0] rem;
   logic [24:0] quo;
   logic [9:0]  be_base;
   res_cls_t    cls_d;
   logic [9:0]  be_d;
   logic [24:0] q_d;
   logic        st_d;

   assign sign_in = x[31];
   assign exp_in  = x[30:23];
   assign frac_in = x[22:0];

   // Shift that brings the top set bit of a subnormal fraction to bit 23.
   always_comb begin
      sh = '0;
      for (int i = 0; i < 23; i++) begin
         if (frac_in[i]) sh = 5'(23 - i);
      end
   end

   assign mant  = (exp_in == 8'd0) ? ({1'b0, frac_in} << sh) : {1'b1, frac_in};
   assign m_one = (mant == 24'h80_0000);

   // quo holds the bits below the leading one of 2^49 / mant. For
   // mant > 2^23 that quotient lies in (2^25, 2^26), so its top bit is
   // always 1 and the first subtraction is done up front.
   always_comb begin
      rem = 25'h100_0000 - {1'b0, mant};
      quo = '0;
      for (int i = 24; i >= 0; i--) begin
         rem = rem << 1;
         if (rem >= {1'b0, mant}) begin
            rem    = rem - {1'b0, mant};
            quo[i] = 1'b1;
         end
      end
   end

   // Biased result exponent before rounding. For mant != 2^23 the quotient
   // represents 2/m, hence the extra -1 relative to an exact power of two.
   //   normal:    253 - exp        subnormal: 252 + sh
   assign be_base = (exp_in != 8'd0) ? (10'd253 - {2'b00, exp_in})
                                     : (10'd252 + {5'b0, sh});

   always_comb begin
      cls_d = CLS_FIN;
      be_d  = be_base + {9'b0, m_one};
      q_d   = m_one ? 25'h0 : quo;
      st_d  = m_one ? 1'b0 : (rem != 25'h0);
      if (exp_in == 8'hFF) begin
         cls_d = (frac_in != 23'h0) ? CLS_NAN : CLS_ZERO;
         // NaN payload rides in the significand field.
         q_d   = {2'b00, frac_in};
         st_d  = 1'b0;
      end else if (exp_in == 8'd0 && frac_in == 23'h0) begin
         cls_d = CLS_INF;
      end
   end

   logic        v1;
   logic        s1;
   res_cls_t    cls1;
   logic [9:0]  be1;
   logic [24:0] q1;
   logic        st1;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         s1   <= 1'b0;
         cls1 <= CLS_ZERO;
         be1  <= '0;
         q1   <= '0;
         st1  <= 1'b0;
      end else begin
         v1   <= valid_in;
         s1   <= sign_in;
         cls1 <= cls_d;
         be1  <= be_d;
         q1   <= q_d;
         st1  <= st_d;
      end
   end

   // ---------------------------------------------------------------- stage 2
   logic        rnd;
   logic        carry;
   logic [22:0] frac_r;
   logic [9:0]  be_r;
   logic [31:0] y_d;
   logic        ovf_d;

   // q1[24:2] is the fraction, q1[1] the round bit, q1[0] plus the division
   // remainder form the sticky bit.
   assign rnd             = q1[1] & (q1[0] | st1 | q1[2]);
   assign {carry, frac_r} = {1'b0, q1[24:2]} + 24'(rnd);
   assign be_r            = be1 + {9'b0, carry};

   always_comb begin
      y_d   = 32'h0;
      ovf_d = 1'b0;
      case (cls1)
         CLS_FIN: begin
            if ($signed(be_r) >= 10'sd255) begin
               y_d   = {s1, 8'hFF, 23'h0};
               ovf_d = 1'b1;
            end else if ($signed(be_r) > 10'sd0) begin
               y_d = {s1, be_r[7:0], frac_r};
            end
            // below 2^-126 flushes to +0
         end
         CLS_INF: begin
            y_d   = {s1, 8'hFF, 23'h0};
            ovf_d = 1'b1;
         end
         CLS_NAN: y_d = {s1, 8'hFF, 1'b1, q1[21:0]};
         default: y_d = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_out <= 1'b0;
         y         <= 32'h0;
         ovf       <= 1'b0;
      end else begin
         valid_out <= v1;
         y         <= y_d;
         ovf       <= ovf_d;
      end
   end

endmodule

// File: tb/tb_finv_pipe.sv
// Self-checking bench for finv_pipe. The reference reciprocal is computed
// in double precision and rounded to binary32 with the flush/overflow rules.
module tb_finv_pipe;

   localparam logic [31:0] IDLE_X = 32'h7F80_0000;   // +inf -> y=0, ovf=0

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [31:0] x;
   logic        valid_out;
   logic [31:0] y;
   logic        ovf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   finv_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .x         (x),
      .valid_out (valid_out),
      .y         (y),
      .ovf       (ovf)
   );

   // Drive one cycle of inputs, let one rising edge pass, settle 1 time unit.
   task automatic cyc(input logic r, input logic v, input logic [31:0] xv);
      rst      = r;
      valid_in = v;
      x        = xv;
      @(posedge clk);
      #1;
   endtask

   // Reference: tol=1 means a normal result where +/-1 in the bit pattern
   // is acceptable; otherwise the pattern must match exactly.
   function automatic void model(input logic [31:0] xv, output logic [31:0] ye,
                                 output logic oe, output bit tol);
      logic        s;
      int          e;
      logic [22:0] f;
      logic [63:0] db;
      logic [63:0] rb;
      real         r;
      int          be;
      int          p;
      logic [24:0] m;
      s   = xv[31];
      e   = int'(xv[30:23]);
      f   = xv[22:0];
      tol = 1'b0;
      oe  = 1'b0;
      ye  = 32'h0;
      if (e == 255) begin
         ye = (f != 23'h0) ? (xv | 32'h0040_0000) : 32'h0;
         return;
      end
      if (e == 0 && f == 23'h0) begin
         ye = {s, 8'hFF, 23'h0};
         oe = 1'b1;
         return;
      end
      if (e != 0) begin
         db = {1'b0, 11'(e + 896), f, 29'b0};
      end else begin
         p = 0;
         for (int i = 0; i < 23; i++) if (f[i]) p = i;
         db = {1'b0, 11'(p + 874), 52'({29'b0, f} << (52 - p))};
      end
      r  = 1.0 / $bitstoreal(db);
      rb = $realtobits(r);
      be = int'(rb[62:52]) - 896;
      m  = {2'b01, rb[51:29]};
      if (rb[28] && ((|rb[27:0]) || m[0])) m = m + 25'd1;
      if (m[24]) be = be + 1;
      if (be >= 255) begin
         ye = {s, 8'hFF, 23'h0};
         oe = 1'b1;
      end else if (be > 0) begin
         ye  = {s, 8'(be), m[22:0]};
         tol = 1'b1;
      end
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         if (i < 2) cyc(1'b1, 1'b1, $urandom());
         else       cyc(1'b0, 1'b0, IDLE_X);
         checks++;
         if (valid_out !== 1'b0 || y !== 32'h0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset[%0d]: got valid_out=%b y=%h ovf=%b, want 0 0 0",
                     i, valid_out, y, ovf);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] tx[16] = '{32'h3F80_0000, 32'h4000_0000, 32'hC080_0000, 32'h4040_0000,
                              32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'h0040_0000,
                              32'h7F7F_FFFF, 32'h7E80_0000, 32'h7F80_0000, 32'h7FA0_0001,
                              32'hFF80_0000, 32'h8040_0000, 32'h0020_0000, 32'hFF00_0000};
      logic [31:0] ty[16] = '{32'h3F80_0000, 32'h3F00_0000, 32'hBE80_0000, 32'h3EAA_AAAB,
                              32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, 32'h7F00_0000,
                              32'h0000_0000, 32'h0080_0000, 32'h0000_0000, 32'h7FE0_0001,
                              32'h0000_0000, 32'hFF00_0000, 32'h7F80_0000, 32'h0000_0000};
      logic        to[16] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      int d;
      for (int k = 0; k < 16; k++) begin
         cyc(1'b0, 1'b1, tx[k]);
         checks++;
         if (valid_out !== 1'b0) begin
            failures++;
            $display("FAIL directed_early x=%h: valid_out=%b one edge after capture, want 0",
                     tx[k], valid_out);
         end
         cyc(1'b0, 1'b0, IDLE_X);
         d = int'({1'b0, y[30:0]}) - int'({1'b0, ty[k][30:0]});
         checks++;
         if (valid_out !== 1'b1 || ovf !== to[k] || y[31] !== ty[k][31] ||
             (k == 3 ? (d < -1 || d > 1) : (y !== ty[k]))) begin
            failures++;
            $display("FAIL directed x=%h: got valid_out=%b y=%h ovf=%b, want 1 %h %b",
                     tx[k], valid_out, y, ovf, ty[k], to[k]);
         end
      end
   endtask

   task automatic test_random();
      localparam int N = 3000;
      logic [31:0] xs[N];
      logic        vs[N];
      logic [31:0] ye;
      logic        oe;
      bit          tol;
      int          d;
      logic [31:0] xv;
      for (int i = 0; i <= N; i++) begin
         if (i < N) begin
            case ($urandom_range(0, 3))
               0: xv = $urandom();
               1: xv = {1'($urandom()), 8'($urandom_range(1, 254)), 23'($urandom())};
               2: xv = {1'($urandom()), 8'h00, 23'($urandom()) >> $urandom_range(0, 22)};
               default: xv = {1'($urandom()),
                              8'($urandom_range(0, 1) ? $urandom_range(0, 3)
                                                      : $urandom_range(251, 254)),
                              ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom())};
            endcase
            xs[i] = xv;
            vs[i] = ($urandom_range(0, 7) != 0);
            cyc(1'b0, vs[i], xs[i]);
         end else begin
            cyc(1'b0, 1'b0, IDLE_X);
         end
         if (i >= 1) begin
            checks++;
            if (valid_out !== vs[i-1]) begin
               failures++;
               $display("FAIL random_valid[%0d]: got %b want %b", i - 1, valid_out, vs[i-1]);
            end else if (vs[i-1]) begin
               model(xs[i-1], ye, oe, tol);
               d = int'({1'b0, y[30:0]}) - int'({1'b0, ye[30:0]});
               checks++;
               if (ovf !== oe || y[31] !== ye[31] ||
                   (tol ? (d < -1 || d > 1) : (y !== ye))) begin
                  failures++;
                  $display("FAIL random[%0d] x=%h: got y=%h ovf=%b, want y=%h ovf=%b (tol=%0d)",
                           i - 1, xs[i-1], y, ovf, ye, oe, tol);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] xs[11];
      logic        vs[11];
      logic [31:0] ye;
      logic        oe;
      bit          tol;
      int          d;
      for (int k = 0; k < 11; k++) begin
         xs[k] = {1'($urandom()), 8'($urandom_range(1, 250)), 23'($urandom())};
         vs[k] = (k != 5);
      end
      for (int k = 0; k < 11; k++) begin
         cyc(1'b0, vs[k], xs[k]);
         if (k >= 1) begin
            model(xs[k-1], ye, oe, tol);
            d = int'({1'b0, y[30:0]}) - int'({1'b0, ye[30:0]});
            checks++;
            if (valid_out !== vs[k-1] ||
                (vs[k-1] && (ovf !== oe || y[31] !== ye[31] || d < -1 || d > 1))) begin
               failures++;
               $display("FAIL b2b[%0d] x=%h: got valid_out=%b y=%h ovf=%b, want %b %h %b",
                        k - 1, xs[k-1], valid_out, y, ovf, vs[k-1], ye, oe);
            end
         end
      end
      // Two valid samples sit in the pipeline; reset must drop them and the
      // sample presented alongside the reset.
      cyc(1'b1, 1'b1, 32'h3F80_0000);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (valid_out !== 1'b0 || y !== 32'h0 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL b2b_flush[%0d]: got valid_out=%b y=%h ovf=%b, want 0 0 0",
                     k, valid_out, y, ovf);
         end
         cyc(1'b0, 1'b0, IDLE_X);
      end
      cyc(1'b0, 1'b1, 32'h4000_0000);
      checks++;
      if (valid_out !== 1'b0 || y !== 32'h0 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL b2b_post_rst_early: got valid_out=%b y=%h ovf=%b, want 0 0 0",
                  valid_out, y, ovf);
      end
      cyc(1'b0, 1'b0, IDLE_X);
      checks++;
      if (valid_out !== 1'b1 || y !== 32'h3F00_0000 || ovf !== 1'b0) begin
         failures++;
         $display("FAIL b2b_post_rst: got valid_out=%b y=%h ovf=%b, want 1 3f000000 0",
                  valid_out, y, ovf);
      end
   endtask

   initial begin
      rst      = 1'b1;
      valid_in = 1'b0;
      x        = IDLE_X;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
